// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_arb_pkg
//  Description : Shared types and constants for the divider arbiter.
//                Holds the controller state encoding, the default watchdog
//                limit and the fixed divide-by-zero result pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    // Operand width of the shared divider
    localparam int DIV_ARB_W = 32;

    // Default watchdog limit, in cycles, for one divider operation
    localparam int DIV_ARB_TIMEOUT_DEF = 40;

    // Quotient returned for a zero divisor (all ones, i.e. -1 when signed)
    localparam logic [DIV_ARB_W-1:0] DZ_QUOT = '1;

    // Controller states
    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_ARM   = 3'd3,
        ST_BUSY  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Two's-complement negation when en is set
    function automatic logic [DIV_ARB_W-1:0] neg_if(input logic [DIV_ARB_W-1:0] x,
                                                    input logic                 en);
        return en ? (~x + DIV_ARB_W'(1)) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : NREQ-wide round-robin arbiter. Grants the first requesting
//                index at or after the priority pointer. The pointer moves to
//                last+1 (mod NREQ) when advance is pulsed.
//  Ports       : clk, rst       - clock, async active-high reset
//                req            - request vector
//                advance, last  - pointer update strobe and last-served index
//                grant          - one-hot grant (combinational)
//                grant_idx      - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    input  logic [PW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan from the pointer, wrapping around, and take the first request seen
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (last == PW'(NREQ - 1)) ? '0 : last + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : div_arbiter
//  Description : Shares one iterative divider among NREQ requesters. Picks a
//                request round-robin, handles a zero divisor locally, runs
//                the divider start/finish handshake and returns the result on
//                the winner's response channel. A watchdog bounds every
//                divider operation; a drain state after reset flushes any
//                operation the divider still has in flight.
//  Config      : DIV_ARB_SIGNED_EN - adds req_signed and signed fix-up
//  Ports       : clk, rst                    - clock, async active-high reset
//                req_valid/ready             - per-requester request handshake
//                req_dividend/divisor        - packed operands, [i*W +: W]
//                req_signed                  - signed op (DIV_ARB_SIGNED_EN)
//                resp_valid/ready            - per-requester response handshake
//                resp_quot/rem/dz/err        - shared response payload
//                div_start/dividend/divisor  - to divider
//                div_finish/divide_zero/res/rem - from divider
//  Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = DIV_ARB_W,
    parameter int TIMEOUT = DIV_ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
`ifdef DIV_ARB_SIGNED_EN
    input  logic [NREQ-1:0]   req_signed,
`endif
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_quot,
    output logic [W-1:0]      resp_rem,
    output logic              resp_dz,
    output logic              resp_err,
    output logic              div_start,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    input  logic              div_finish,
    input  logic              div_divide_zero,
    input  logic [W-1:0]      div_res,
    input  logic [W-1:0]      div_rem
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    logic [PW-1:0]   r_tag;
    logic [WDW-1:0]  r_wd;
    logic            r_div_start;
    logic [W-1:0]    r_div_dividend;
    logic [W-1:0]    r_div_divisor;
    logic [NREQ-1:0] r_resp_valid;
    logic [W-1:0]    r_resp_quot;
    logic [W-1:0]    r_resp_rem;
    logic            r_resp_dz;
    logic            r_resp_err;
    logic            r_neg_q;
    logic            r_neg_r;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_grant_idx;
    logic            w_accept;
    logic            w_resp_hs;
    logic            w_wd_expired;
    logic [NREQ-1:0] w_tag_onehot;
    logic [W-1:0]    w_sel_dividend;
    logic [W-1:0]    w_sel_divisor;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic            w_neg_q;
    logic            w_neg_r;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_resp_hs),
        .last      (r_tag),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Only IDLE accepts; grant is one-hot so at most one ready bit is high
    assign req_ready    = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_accept     = (r_state == ST_IDLE) && (|w_grant);
    assign w_resp_hs    = (r_state == ST_RESP) && resp_ready[r_tag];
    assign w_wd_expired = (r_wd == WDW'(TIMEOUT - 1));
    assign w_tag_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_tag;

    assign w_sel_dividend = req_dividend[w_grant_idx*W +: W];
    assign w_sel_divisor  = req_divisor[w_grant_idx*W +: W];

    // ------------------------------------------------------------------------
    // Operand preparation: the divider only ever sees magnitudes
    // ------------------------------------------------------------------------
`ifdef DIV_ARB_SIGNED_EN
    logic w_sgn;
    logic w_a_neg;
    logic w_b_neg;

    assign w_sgn   = req_signed[w_grant_idx];
    assign w_a_neg = w_sgn & w_sel_dividend[W-1];
    assign w_b_neg = w_sgn & w_sel_divisor[W-1];
    assign w_a_mag = neg_if(w_sel_dividend, w_a_neg);
    assign w_b_mag = neg_if(w_sel_divisor, w_b_neg);
    // Quotient sign follows the XOR of operand signs; remainder follows the
    // dividend. MIN/-1 falls out naturally: |MIN|/1 = MIN, negated = MIN.
    assign w_neg_q = w_a_neg ^ w_b_neg;
    assign w_neg_r = w_a_neg;
`else
    assign w_a_mag = w_sel_dividend;
    assign w_b_mag = w_sel_divisor;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_DRAIN;
            r_tag          <= '0;
            r_wd           <= '0;
            r_div_start    <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_resp_valid   <= '0;
            r_resp_quot    <= '0;
            r_resp_rem     <= '0;
            r_resp_dz      <= 1'b0;
            r_resp_err     <= 1'b0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                // Divider may still be busy with an op from before reset;
                // wait for it to finish (or give up) and throw the result away
                ST_DRAIN: begin
                    if (div_finish || w_wd_expired) begin
                        r_wd    <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end

                ST_IDLE: begin
                    if (w_accept) begin
                        r_tag <= w_grant_idx;
                        if (w_sel_divisor == '0) begin
                            r_resp_valid <= w_grant;
                            r_resp_quot  <= W'(DZ_QUOT);
                            r_resp_rem   <= w_sel_dividend;
                            r_resp_dz    <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_state      <= ST_RESP;
                        end else begin
                            r_div_dividend <= w_a_mag;
                            r_div_divisor  <= w_b_mag;
                            r_neg_q        <= w_neg_q;
                            r_neg_r        <= w_neg_r;
                            r_div_start    <= 1'b1;
                            r_state        <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= ST_ARM;
                end

                // finish may still be high from the previous op; only trust
                // it after it has been seen low
                ST_ARM: begin
                    if (w_wd_expired) begin
                        r_resp_valid <= w_tag_onehot;
                        r_resp_quot  <= '0;
                        r_resp_rem   <= '0;
                        r_resp_dz    <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                        if (!div_finish) begin
                            r_state <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    if (div_finish) begin
                        r_resp_valid <= w_tag_onehot;
                        r_resp_quot  <= neg_if(div_res, r_neg_q);
                        r_resp_rem   <= neg_if(div_rem, r_neg_r);
                        r_resp_dz    <= div_divide_zero;
                        r_resp_err   <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (w_wd_expired) begin
                        r_resp_valid <= w_tag_onehot;
                        r_resp_quot  <= '0;
                        r_resp_rem   <= '0;
                        r_resp_dz    <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end

                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= '0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_DRAIN;
                end
            endcase
        end
    end

    assign div_start    = r_div_start;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign resp_valid   = r_resp_valid;
    assign resp_quot    = r_resp_quot;
    assign resp_rem     = r_resp_rem;
    assign resp_dz      = r_resp_dz;
    assign resp_err     = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_arbiter
//  Description : Self-checking bench for div_arbiter with a behavioural
//                iterative divider model and an expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 40;
    localparam int DIV_LAT = 32;

    typedef struct {
        int          tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        err;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [W-1:0]      resp_quot;
    logic [W-1:0]      resp_rem;
    logic              resp_dz;
    logic              resp_err;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_finish      = 1'b1;
    logic              div_divide_zero = 1'b0;
    logic [W-1:0]      div_res         = '0;
    logic [W-1:0]      div_rem         = '0;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   starts   = 0;
    int   dcnt     = 0;
    logic hang     = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
`ifdef DIV_ARB_SIGNED_EN
        .req_signed      (req_signed),
`endif
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_quot       (resp_quot),
        .resp_rem        (resp_rem),
        .resp_dz         (resp_dz),
        .resp_err        (resp_err),
        .div_start       (div_start),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_finish      (div_finish),
        .div_divide_zero (div_divide_zero),
        .div_res         (div_res),
        .div_rem         (div_rem)
    );

    // Iterative divider model: finish drops on start, rises DIV_LAT cycles
    // later with the unsigned result, and stays high until the next start.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) begin
            starts     <= starts + 1;
            div_finish <= 1'b0;
            dcnt       <= DIV_LAT;
            m_a        <= div_dividend;
            m_b        <= div_divisor;
        end else if (!div_finish && !hang && dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                div_finish      <= 1'b1;
                div_divide_zero <= (m_b == 0);
                div_res         <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
                div_rem         <= (m_b == 0) ? m_a : m_a % m_b;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int tag, input logic [31:0] a,
                                   input logic [31:0] b, input logic sgn);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        e.dz  = (b == 0);
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'h0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Present a request, wait for acceptance, queue its expected response and
    // check the first-cycle behaviour (start pulse or immediate dz response).
    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input exp_t e);
        logic ok;
        int   s0;
        ok = 1'b0;
        req_dividend[idx*W +: W] = a;
        req_divisor[idx*W +: W]  = b;
        req_signed[idx]          = sgn;
        req_valid[idx]           = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[idx]) ok = 1'b1;
        end
        chk("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            sb.push_back(e);
            s0 = starts;
            @(posedge clk);
            #1;
            acc_cyc        = cyc;
            req_valid[idx] = 1'b0;
            @(negedge clk);
            if (b != 0) begin
                chk("start_at_cycle1", {31'd0, div_start}, 32'd1);
            end else begin
                chk("dz_resp_at_cycle1", {30'd0, resp_valid}, 32'd1 << idx);
                chk("dz_no_start", starts - s0, 32'd0);
            end
        end else begin
            req_valid[idx] = 1'b0;
        end
    endtask

    // Wait for a response, compare against the queue head, then consume it.
    task automatic wait_resp(input int limit, output int lat);
        logic ok;
        exp_t e;
        ok  = 1'b0;
        lat = -1;
        for (int t = 0; t < limit && !ok; t++) begin
            if (resp_valid != 0) ok = 1'b1;
            else @(negedge clk);
        end
        chk("resp_seen", {31'd0, ok}, 32'd1);
        if (ok) begin
            lat = cyc - acc_cyc;
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("resp_tag",  {30'd0, resp_valid}, 32'd1 << e.tag);
                chk("resp_quot", resp_quot, e.q);
                chk("resp_rem",  resp_rem, e.r);
                chk("resp_dz",   {31'd0, resp_dz}, {31'd0, e.dz});
                chk("resp_err",  {31'd0, resp_err}, {31'd0, e.err});
            end
            chk("no_accept_in_resp", {30'd0, req_ready}, 32'd0);
            resp_ready = resp_valid;
            @(posedge clk);
            #1;
            resp_ready = '0;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready",  {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_resp_quot",  resp_quot, 32'd0);
        chk("rst_resp_rem",   resp_rem, 32'd0);
        chk("rst_flags",      {30'd0, resp_dz, resp_err}, 32'd0);
        chk("rst_div_start",  {31'd0, div_start}, 32'd0);
        chk("rst_div_ops",    div_dividend | div_divisor, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int   lat;
        int   prev_g;
        int   g;
        int   bad;
        logic ok;
        logic [31:0] opa [NREQ];
        logic [31:0] opb [NREQ];
        exp_t e;

        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = '0;
        resp_ready   = '0;

        vecs[0] = '{0, 32'd100,        32'd7,      32'd14,         32'd2,      1'b0};
        vecs[1] = '{1, 32'h0000_1234,  32'd0,      32'hFFFF_FFFF,  32'h1234,   1'b1};
        vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,      32'hFFFF_FFFF,  32'd0,      1'b0};
        vecs[3] = '{1, 32'd5,          32'd10,     32'd0,          32'd5,      1'b0};
        vecs[4] = '{0, 32'h8000_0000,  32'h10,     32'h0800_0000,  32'd0,      1'b0};
        vecs[5] = '{1, 32'd1000000,    32'd999,    32'd1001,       32'd1,      1'b0};
        vecs[6] = '{0, 32'd0,          32'd3,      32'd0,          32'd0,      1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven single transactions ----------------
        foreach (vecs[i]) begin
            e = '{vecs[i].idx, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0};
            send(vecs[i].idx, vecs[i].a, vecs[i].b, 1'b0, e);
            wait_resp(TIMEOUT + 4, lat);
        end

        // ---------------- both requesters continuously valid --------------
        opa[0] = 32'd200; opb[0] = 32'd9;
        opa[1] = 32'd301; opb[1] = 32'd10;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*W +: W] = opa[i];
            req_divisor[i*W +: W]  = opb[i];
        end
        req_valid = '1;
        prev_g = -1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            g  = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                if (req_ready != 0) begin
                    ok = 1'b1;
                    g  = req_ready[1] ? 1 : 0;
                end
            end
            chk("alt_grant_seen", {31'd0, ok}, 32'd1);
            if (!ok) break;
            if (prev_g >= 0) chk("alt_grant_order", g, 1 - prev_g);
            prev_g = g;
            sb.push_back(model(g, opa[g], opb[g], 1'b0));
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            opa[g] = 32'd1000 + 32'(k * 37);
            opb[g] = 32'd3 + 32'(k);
            req_dividend[g*W +: W] = opa[g];
            req_divisor[g*W +: W]  = opb[g];
            wait_resp(TIMEOUT + 4, lat);
        end
        req_valid = '0;
        sb.delete();

        // ---------------- watchdog expiry, then normal op -----------------
        hang = 1'b1;
        send(0, 32'd9, 32'd3, 1'b0, '{0, 32'd0, 32'd0, 1'b0, 1'b1});
        wait_resp(TIMEOUT + 10, lat);
        chk("wd_latency_bounds", {31'd0, (lat >= TIMEOUT && lat <= TIMEOUT + 4)}, 32'd1);
        hang = 1'b0;
        send(1, 32'd81, 32'd9, 1'b0, model(1, 32'd81, 32'd9, 1'b0));
        wait_resp(TIMEOUT + 4, lat);

        // ---------------- reset mid-BUSY, drain stale op ------------------
        send(0, 32'd77, 32'd7, 1'b0, model(0, 32'd77, 32'd7, 1'b0));
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #2;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        bad = 0;
        for (int t = 0; t < 3 * TIMEOUT && !div_finish; t++) begin
            if (req_ready != 0 || resp_valid != 0) bad++;
            @(negedge clk);
        end
        chk("drain_holds_off", bad, 32'd0);
        send(1, 32'd50, 32'd5, 1'b0, '{1, 32'd10, 32'd0, 1'b0, 1'b0});
        wait_resp(TIMEOUT + 4, lat);

`ifdef DIV_ARB_SIGNED_EN
        // ---------------- signed operations -------------------------------
        send(0, 32'hFFFF_FFF9, 32'd2, 1'b1, '{0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0});
        wait_resp(TIMEOUT + 4, lat);
        send(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{1, 32'h8000_0000, 32'd0, 1'b0, 1'b0});
        wait_resp(TIMEOUT + 4, lat);
        send(0, 32'hFFFF_FFFB, 32'd0, 1'b1, '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0});
        wait_resp(TIMEOUT + 4, lat);
        send(1, 32'd100, 32'hFFFF_FFF9, 1'b1, model(1, 32'd100, 32'hFFFF_FFF9, 1'b1));
        wait_resp(TIMEOUT + 4, lat);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
# div_arbiter

Shares one iterative 32-bit `divider` between NREQ requesters (e.g. integer pipeline and CSR/debug path) with per-requester valid/ready request and response channels. Arbitrates round-robin, sequences the divider's `start`/`finish` handshake, handles divide-by-zero without the divider, and guards the divider with a watchdog. Sits between the requesters and the single `divider` instance.

## Interface
- `NREQ`, 2: number of requesters (2..4)
- `W`, 32: operand width; fixed to the divider width
- `TIMEOUT`, 40: watchdog limit in cycles for one divider operation
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in NREQ: request present
- `req_ready` out NREQ: request accepted this cycle
- `req_dividend`, `req_divisor` in NREQ*W: packed operands, requester i at [i*W +: W]
- `req_signed` in NREQ: signed operation (only with `DIV_ARB_SIGNED_EN`)
- `resp_valid` out NREQ: response present for requester i
- `resp_ready` in NREQ: response consumed
- `resp_quot`, `resp_rem` out W: shared response data, valid for the asserted `resp_valid` bit
- `resp_dz` out 1: divide-by-zero flag
- `resp_err` out 1: watchdog expiry flag
- `div_start` out 1; `div_dividend`, `div_divisor` out W: to divider
- `div_finish`, `div_divide_zero` in 1; `div_res`, `div_rem` in W: from divider

## Operation
- States: DRAIN, IDLE, ISSUE, ARM, BUSY, RESP.
- DRAIN (reset state): flushes any divider operation left in flight across reset. Exits to IDLE on `div_finish`=1 or watchdog expiry. Result is discarded.
- IDLE: the round-robin winner among `req_valid` gets `req_ready`=1 combinationally. At most one `req_ready` bit is high. On handshake, latch operands and tag.
  - Divisor 0 → RESP with quot=all-ones, rem=dividend, `resp_dz`=1. The divider is not started.
  - Otherwise → ISSUE.
- ISSUE: `div_start`=1 for exactly one cycle; clear watchdog; → ARM.
- ARM: wait for `div_finish`=0, so the stale finish from the previous op is ignored; then → BUSY.
- BUSY: on `div_finish`=1, capture `div_res`/`div_rem`; → RESP.
- Watchdog: counts in ARM and BUSY. At `TIMEOUT` → RESP with `resp_err`=1 and quot=rem=0.
- `div_dividend`/`div_divisor` are held stable from ISSUE through BUSY.
- RESP: `resp_valid[tag]`=1 and data held until `resp_ready[tag]`. On handshake → IDLE, and the priority pointer moves to tag+1 mod NREQ.
- Requests presented outside IDLE are not accepted and must be held by the requester.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_quot`=`resp_rem`=0, `resp_dz`=`resp_err`=0, `div_start`=0, `div_dividend`=`div_divisor`=0, pointer=0, state=DRAIN.
- Reset mid-operation: the pending request is dropped with no response. The divider is not reset by this block; DRAIN covers it.

## Timing
- Request handshake at cycle 0 → `div_start` at cycle 1.
- The response appears one cycle after the divider's `finish` rises; about 35 cycles for nonzero divisors.
- Divide-by-zero response appears at cycle 1.
- Back-to-back: the next request is accepted no earlier than the cycle after the response handshake.

## Configuration
- `DIV_ARB_SIGNED_EN` defined: the `req_signed` port exists.
  - Signed ops send operand magnitudes to the divider.
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Divide-by-zero returns quot=-1, rem=dividend.
  - MIN/-1 returns quot=MIN, rem=0.
- Not defined: no `req_signed` port; all ops are unsigned.

## Structure
- Package `div_arb_pkg`: state enum, `DIV_ARB_TIMEOUT_DEF`, divide-by-zero result constants.
- Sub-module `rr_arbiter`: NREQ-wide round-robin grant with pointer-update input.
- Sign fix-up stays inline, guarded by the macro.

## Test plan
- Req0 100/7 → `resp_valid[0]` with quot=14, rem=2, dz=0, err=0, within TIMEOUT+4 cycles of acceptance.
- Req1 divisor 0, dividend 0x1234 → at cycle 1: quot=0xFFFFFFFF, rem=0x1234, dz=1; `div_start` never asserted.
- Both requesters continuously valid → grants alternate 0,1,0,1; each response matches its own operands.
- Divider model never raises `finish` → `resp_err`=1, quot=rem=0 after TIMEOUT cycles; the next request completes normally.
- `rst` asserted mid-BUSY, then divider finishes its stale op → DRAIN discards it; the next request (50/5) returns quot=10, rem=0.
- With `DIV_ARB_SIGNED_EN`: -7/2 → quot=-3, rem=-1; 0x80000000/-1 → quot=0x80000000, rem=0.
